// File: rtl/cic_rate_ctrl.sv
// Run-time rate controller for the four-stage CIC decimator.
// Holds the decimation factor and takes factor changes from the host over a
// valid/ready handshake. Each change flushes the filter with a reset pulse,
// and the first SETTLE_OUTPUTS decimated samples after a flush are discarded.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_FLUSH  | CIC held in reset for FLUSH_CYCLES clocks, host requests held off
// ST_SETTLE | CIC running, comb stages still filling, output strobes discarded
// ST_RUN    | CIC running, settled samples forwarded with a one-clock latency
module cic_rate_ctrl #(
  parameter int DATA_WIDTH     = 15,
  parameter int DEFAULT_FACTOR = 16,
  parameter int MAX_FACTOR     = 1024,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_OUTPUTS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  req_valid,
  input  logic [15:0]           req_factor,
  output logic                  req_ready,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  output logic                  busy,
  output logic [15:0]           cic_factor,
  output logic                  cic_ce,
  output logic                  cic_rst,
  input  logic                  cic_ce_out,
  input  logic [DATA_WIDTH-1:0] cic_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Counter widths leave one spare bit so the terminal compare never aliases.
  localparam int FCW = $clog2(FLUSH_CYCLES) + 1;
  localparam int SCW = $clog2(SETTLE_OUTPUTS) + 1;

  localparam logic [FCW-1:0] FLUSH_LAST  = FCW'(FLUSH_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_OUTPUTS - 1);
  localparam logic [15:0]    FACTOR_MIN  = 16'd2;
  localparam logic [15:0]    FACTOR_MAX  = 16'(MAX_FACTOR);
  localparam logic [15:0]    FACTOR_RST  = 16'(DEFAULT_FACTOR);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                  state_q,      state_d;
  logic [15:0]             factor_q,     factor_d;
  logic [FCW-1:0]          flush_cnt_q,  flush_cnt_d;
  logic [SCW-1:0]          settle_cnt_q, settle_cnt_d;
  logic                    ack_q,        ack_d;
  logic                    err_q,        err_d;
  logic                    ovalid_q,     ovalid_d;
  logic [DATA_WIDTH-1:0]   odata_q,      odata_d;

  logic                    req_take;
  logic                    factor_legal;
  logic                    reconfig;

  // Handshake decode: a transfer happens whenever the host is not held off.
  always_comb begin
    req_take     = req_valid && (state_q != ST_FLUSH);
    factor_legal = (req_factor >= FACTOR_MIN) && (req_factor <= FACTOR_MAX);
    reconfig     = req_take && factor_legal && (req_factor != factor_q);
  end

  // Next-state logic; an accepted reconfiguration outranks a same-cycle strobe.
  always_comb begin
    state_d      = state_q;
    factor_d     = factor_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    ovalid_d     = 1'b0;
    odata_d      = odata_q;

    if (req_take) begin
      if (factor_legal) begin
        ack_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d      = ST_SETTLE;
          flush_cnt_d  = '0;
          settle_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (reconfig) begin
          state_d      = ST_FLUSH;
          factor_d     = req_factor;
          flush_cnt_d  = '0;
          settle_cnt_d = '0;
        end else if (cic_ce_out) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_RUN;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (reconfig) begin
          state_d      = ST_FLUSH;
          factor_d     = req_factor;
          flush_cnt_d  = '0;
          settle_cnt_d = '0;
        end else if (cic_ce_out) begin
          ovalid_d = 1'b1;
          odata_d  = cic_data;
        end
      end

      default: begin
        state_d      = ST_FLUSH;
        flush_cnt_d  = '0;
        settle_cnt_d = '0;
      end
    endcase
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_FLUSH;
      factor_q     <= FACTOR_RST;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      ovalid_q     <= 1'b0;
      odata_q      <= '0;
    end else begin
      state_q      <= state_d;
      factor_q     <= factor_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      ovalid_q     <= ovalid_d;
      odata_q      <= odata_d;
    end
  end

  // Filter control decoded straight from state so the CIC sees no extra lag.
  always_comb begin
    req_ready  = (state_q != ST_FLUSH);
    busy       = (state_q != ST_RUN);
    cic_rst    = (state_q == ST_FLUSH);
    cic_ce     = (state_q != ST_FLUSH) && in_valid;
    cic_factor = factor_q;
    cfg_ack    = ack_q;
    cfg_err    = err_q;
    out_valid  = ovalid_q;
    out_data   = odata_q;
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
module tb_cic_rate_ctrl;

  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          req_valid;
  logic [15:0]   req_factor;
  logic          req_ready;
  logic          cfg_ack;
  logic          cfg_err;
  logic          busy;
  logic [15:0]   cic_factor;
  logic          cic_ce;
  logic          cic_rst;
  logic          cic_ce_out;
  logic [DW-1:0] cic_data;
  logic          out_valid;
  logic [DW-1:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  cic_rate_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .req_valid  (req_valid),
    .req_factor (req_factor),
    .req_ready  (req_ready),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .cic_factor (cic_factor),
    .cic_ce     (cic_ce),
    .cic_rst    (cic_rst),
    .cic_ce_out (cic_ce_out),
    .cic_data   (cic_data),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [DW-1:0] d, input bit exp_out);
    if (exp_out) sb.push_back(d);
    cic_ce_out = 1'b1;
    cic_data   = d;
    tick();
    cic_ce_out = 1'b0;
    cic_data   = DW'($urandom);
    chk("out_valid_after_strobe", {31'd0, out_valid}, {31'd0, exp_out});
  endtask

  task automatic request(input logic [15:0] f);
    req_valid  = 1'b1;
    req_factor = f;
    tick();
    req_valid  = 1'b0;
  endtask

  // Called with the flush counter at zero; walks the whole flush window.
  task automatic expect_flush();
    for (int i = 0; i < 4; i++) begin
      chk("cic_rst_in_flush", {31'd0, cic_rst}, 32'd1);
      chk("req_ready_in_flush", {31'd0, req_ready}, 32'd0);
      chk("cic_ce_in_flush", {31'd0, cic_ce}, 32'd0);
      tick();
    end
    chk("cic_rst_after_flush", {31'd0, cic_rst}, 32'd0);
    chk("req_ready_after_flush", {31'd0, req_ready}, 32'd1);
    chk("busy_in_settle", {31'd0, busy}, 32'd1);
  endtask

  // Scoreboard: every settled output must match the oldest pushed sample.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected_out: observed out_data %0h expected no output", out_data);
      end
      if (sb.size() != 0) begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        n_vec++;
        assert (out_data === e) else begin
          n_err++;
          $error("FAIL sb_out_data: observed %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    reset      = 1'b0;
    in_valid   = 1'b1;
    req_valid  = 1'b0;
    req_factor = 16'd0;
    cic_ce_out = 1'b0;
    cic_data   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_cic_rst", {31'd0, cic_rst}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_cic_ce", {31'd0, cic_ce}, 32'd0);
    chk("rst_cic_factor", {16'd0, cic_factor}, 32'd16);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cfg_ack", {31'd0, cfg_ack}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_out_data", {17'd0, out_data}, 32'd0);

    // Release reset: flush, two suppressed strobes, then settled data
    reset = 1'b1;
    expect_flush();
    chk("settle_cic_ce", {31'd0, cic_ce}, 32'd1);
    in_valid = 1'b0;
    #1;
    chk("settle_cic_ce_gated", {31'd0, cic_ce}, 32'd0);
    in_valid = 1'b1;
    strobe(15'h1111, 1'b0);
    chk("busy_after_1st_suppr", {31'd0, busy}, 32'd1);
    strobe(15'h2222, 1'b0);
    chk("busy_on_run", {31'd0, busy}, 32'd0);
    tick();
    d = 15'h3a5c;
    strobe(d, 1'b1);
    tick();
    chk("out_valid_pulse_ends", {31'd0, out_valid}, 32'd0);
    tick();
    chk("out_data_held", {17'd0, out_data}, {17'd0, d});

    // Illegal factors: error pulse, nothing else moves
    request(16'd1);
    chk("err_f1", {31'd0, cfg_err}, 32'd1);
    chk("err_f1_noack", {31'd0, cfg_ack}, 32'd0);
    chk("err_f1_factor", {16'd0, cic_factor}, 32'd16);
    chk("err_f1_noflush", {31'd0, cic_rst}, 32'd0);
    tick();
    chk("err_pulse_ends", {31'd0, cfg_err}, 32'd0);
    request(16'd0);
    chk("err_f0", {31'd0, cfg_err}, 32'd1);
    chk("err_f0_busy", {31'd0, busy}, 32'd0);
    request(16'd2000);
    chk("err_f2000", {31'd0, cfg_err}, 32'd1);
    chk("err_f2000_factor", {16'd0, cic_factor}, 32'd16);
    request(16'd1025);
    chk("err_f1025", {31'd0, cfg_err}, 32'd1);
    chk("err_f1025_noflush", {31'd0, cic_rst}, 32'd0);
    tick();
    strobe(15'h0abc, 1'b1);

    // Same factor together with a strobe: ack, sample still forwarded
    d = 15'h7001;
    sb.push_back(d);
    req_valid  = 1'b1;
    req_factor = 16'd16;
    cic_ce_out = 1'b1;
    cic_data   = d;
    tick();
    req_valid  = 1'b0;
    cic_ce_out = 1'b0;
    chk("same_ack", {31'd0, cfg_ack}, 32'd1);
    chk("same_noflush", {31'd0, cic_rst}, 32'd0);
    chk("same_out_valid", {31'd0, out_valid}, 32'd1);
    chk("same_factor", {16'd0, cic_factor}, 32'd16);

    // Legal change to 8
    tick();
    request(16'd8);
    chk("chg8_ack", {31'd0, cfg_ack}, 32'd1);
    chk("chg8_factor", {16'd0, cic_factor}, 32'd8);
    expect_flush();
    chk("chg8_ack_ended", {31'd0, cfg_ack}, 32'd0);
    strobe(15'h0101, 1'b0);
    strobe(15'h0202, 1'b0);
    tick();
    strobe(15'h5555, 1'b1);
    tick();

    // Collision in RUN: request 32 with a strobe; the sample is dropped
    req_valid  = 1'b1;
    req_factor = 16'd32;
    cic_ce_out = 1'b1;
    cic_data   = 15'h6666;
    tick();
    cic_ce_out = 1'b0;
    chk("coll_out_valid", {31'd0, out_valid}, 32'd0);
    chk("coll_ack", {31'd0, cfg_ack}, 32'd1);
    chk("coll_flush", {31'd0, cic_rst}, 32'd1);
    chk("coll_factor", {16'd0, cic_factor}, 32'd32);

    // Hold request 4 through the flush; taken on the first SETTLE cycle
    req_factor = 16'd4;
    for (int i = 0; i < 4; i++) begin
      chk("held_req_ready", {31'd0, req_ready}, 32'd0);
      chk("held_factor", {16'd0, cic_factor}, 32'd32);
      if (i > 0) chk("held_no_ack", {31'd0, cfg_ack}, 32'd0);
      tick();
    end
    chk("held_settle_ready", {31'd0, req_ready}, 32'd1);
    chk("held_settle_rst", {31'd0, cic_rst}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("held_ack", {31'd0, cfg_ack}, 32'd1);
    chk("held_factor4", {16'd0, cic_factor}, 32'd4);
    expect_flush();

    // Mid-settle reset after one suppressed strobe
    strobe(15'h0777, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_cic_rst", {31'd0, cic_rst}, 32'd1);
    chk("midrst_factor", {16'd0, cic_factor}, 32'd16);
    chk("midrst_ack", {31'd0, cfg_ack}, 32'd0);
    chk("midrst_err", {31'd0, cfg_err}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {17'd0, out_data}, 32'd0);
    expect_flush();
    strobe(15'h0123, 1'b0);
    chk("midrst_busy_1", {31'd0, busy}, 32'd1);
    strobe(15'h0456, 1'b0);
    chk("midrst_busy_run", {31'd0, busy}, 32'd0);
    tick();
    strobe(15'h4321, 1'b1);
    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
